// File: rtl/tpu_issue_sequencer.sv
// tpu_issue_sequencer: buffers host instructions in a small FIFO and issues
// them to the TPU core one at a time, inserting NOP fill after COMPUTE and
// a wait-then-capture window after READ.
module tpu_issue_sequencer #(
    parameter int DEPTH          = 4,
    parameter int COMPUTE_CYCLES = 4,
    parameter int RD_LAT         = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic        flush,
    output logic [15:0] tpu_instr,
    input  logic [7:0]  tpu_result,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic        busy
);

    localparam int AW   = $clog2(DEPTH);
    localparam int MAXC = (COMPUTE_CYCLES > RD_LAT) ? COMPUTE_CYCLES : RD_LAT;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0]    OP_COMPUTE = 3'b011;
    localparam logic [2:0]    OP_READ    = 3'b100;
    localparam logic [AW:0]   PTR_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO   = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STALL  = 2'd1,
        WAITRD = 2'd2
    } state_t;

    logic [15:0]   r_mem [DEPTH];
    logic [AW:0]   r_wrPtr;
    logic [AW:0]   r_rdPtr;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_tpuInstr;
    logic          r_resValid;
    logic [7:0]    r_resData;

    state_t        w_nextState;
    logic [CW-1:0] w_cntNext;
    logic [15:0]   w_tpuInstrNext;
    logic [15:0]   w_head;
    logic [2:0]    w_headOp;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_capture;

    // FIFO status comes from comparing pointers that carry an extra wrap bit
    assign w_empty  = (r_wrPtr == r_rdPtr);
    assign w_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                      (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_head   = r_mem[r_rdPtr[AW-1:0]];
    assign w_headOp = w_head[15:13];

    assign in_ready = !w_full && !flush && !rst;
    assign w_push   = in_valid && in_ready;

    // FIFO pointers; reset and flush both empty the queue
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
            if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
        end
    end

    // FIFO storage, written on every accepted push
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr[AW-1:0]] <= in_instr;
    end

    // State and busy-window counter register
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_cntNext;
        end
    end

    // Next-state: STALL counts NOP cycles down to 1, WAITRD counts down to the sample edge at 0
    always_comb begin
        w_nextState = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    if (w_headOp == OP_COMPUTE) begin
                        w_nextState = STALL;
                        w_cntNext   = CW'(COMPUTE_CYCLES);
                    end else if (w_headOp == OP_READ) begin
                        w_nextState = WAITRD;
                        w_cntNext   = CW'(RD_LAT);
                    end
                end
            end
            STALL: begin
                w_cntNext = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) w_nextState = IDLE;
            end
            WAITRD: begin
                if (r_cnt == CNT_ZERO) begin
                    w_nextState = IDLE;
                end else begin
                    w_cntNext = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    // Output decode: pop only from IDLE, capture the result on the last WAITRD cycle
    always_comb begin
        w_pop          = (r_state == IDLE) && !w_empty;
        w_tpuInstrNext = w_pop ? w_head : 16'h0000;
        w_capture      = (r_state == WAITRD) && (r_cnt == CNT_ZERO);
    end

    // Registered outputs; an aborted READ keeps the previous result data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tpuInstr <= 16'h0000;
            r_resValid <= 1'b0;
            r_resData  <= 8'h00;
        end else if (flush) begin
            r_tpuInstr <= 16'h0000;
            r_resValid <= 1'b0;
        end else begin
            r_tpuInstr <= w_tpuInstrNext;
            r_resValid <= w_capture;
            if (w_capture) r_resData <= tpu_result;
        end
    end

    assign tpu_instr = r_tpuInstr;
    assign res_valid = r_resValid;
    assign res_data  = r_resData;
    assign busy      = !w_empty || (r_state != IDLE) || (r_tpuInstr != 16'h0000);

endmodule

// File: tb/tb_tpu_issue_sequencer.sv
// Testbench for tpu_issue_sequencer: directed scenarios followed by random
// traffic, all checked against a timeline-based reference model.
module tb_tpu_issue_sequencer;

    localparam int DEPTH          = 4;
    localparam int COMPUTE_CYCLES = 4;
    localparam int RD_LAT         = 1;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        flush;
    logic [15:0] tpu_instr;
    logic [7:0]  tpu_result;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        busy;

    tpu_issue_sequencer #(
        .DEPTH(DEPTH),
        .COMPUTE_CYCLES(COMPUTE_CYCLES),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instr(in_instr),
        .flush(flush),
        .tpu_instr(tpu_instr),
        .tpu_result(tpu_result),
        .res_valid(res_valid),
        .res_data(res_data),
        .busy(busy)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: queue of pending words plus a timeline of when the
    // sequencer is next free to issue and when a READ result is sampled.
    logic [15:0] modelQ [$];
    int          cyc        = 0;
    int          freeCycle  = 0;
    int          readSample = -1;
    logic [15:0] expTpu     = 16'h0000;
    logic        expRv      = 1'b0;
    logic [7:0]  expRd      = 8'h00;
    logic        expReady;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic modelEdge();
        logic [15:0] w;
        int          issueCycle;
        bit          canPush;
        if (rst) begin
            modelQ.delete();
            freeCycle  = cyc + 1;
            readSample = -1;
            expTpu     = 16'h0000;
            expRv      = 1'b0;
            expRd      = 8'h00;
        end else if (flush) begin
            modelQ.delete();
            freeCycle  = cyc + 1;
            readSample = -1;
            expTpu     = 16'h0000;
            expRv      = 1'b0;
        end else begin
            canPush = in_valid && (modelQ.size() < DEPTH);
            expRv   = (readSample == cyc);
            if (expRv) begin
                expRd      = tpu_result;
                readSample = -1;
            end
            if ((cyc >= freeCycle) && (modelQ.size() > 0)) begin
                w          = modelQ.pop_front();
                expTpu     = w;
                issueCycle = cyc + 1;
                if (w[15:13] == 3'b011) begin
                    freeCycle = issueCycle + COMPUTE_CYCLES;
                end else if (w[15:13] == 3'b100) begin
                    readSample = issueCycle + RD_LAT;
                    freeCycle  = issueCycle + RD_LAT + 1;
                end else begin
                    freeCycle = issueCycle;
                end
            end else begin
                expTpu = 16'h0000;
            end
            if (canPush) modelQ.push_back(in_instr);
        end
        cyc++;
    endtask

    // One full cycle: drive inputs, check in_ready, clock, then check registered outputs
    task automatic applyStimulus(input logic v, input logic [15:0] instr,
                                 input logic fl, input logic rs,
                                 input logic [7:0] res);
        @(negedge clk);
        in_valid   = v;
        in_instr   = instr;
        flush      = fl;
        rst        = rs;
        tpu_result = res;
        #1;
        expReady = !rs && !fl && (modelQ.size() < DEPTH);
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("tpu_instr", {16'd0, tpu_instr}, {16'd0, expTpu});
        checkOutput("res_valid", {31'd0, res_valid}, {31'd0, expRv});
        checkOutput("res_data", {24'd0, res_data}, {24'd0, expRd});
        checkOutput("busy", {31'd0, busy},
                    {31'd0, (modelQ.size() > 0) || (cyc < freeCycle) || (expTpu != 16'h0000)});
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h3C);
    endtask

    logic [15:0] burst [6];
    int          idx;
    int          guard;
    logic [2:0]  op;
    logic [15:0] rw;

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_instr   = 16'h0000;
        flush      = 1'b0;
        tpu_result = 8'h00;

        // Reset, then three plain words back to back
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 16'h2002, 1'b0, 1'b0, 8'h00);
        idleCycles(4);

        // COMPUTE followed by a plain word
        applyStimulus(1'b1, 16'h6000, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0, 8'h00);
        idleCycles(8);

        // READ with a fixed core result
        applyStimulus(1'b1, 16'h8000, 1'b0, 1'b0, 8'hA5);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'hA5);
        idleCycles(2);

        // Back-pressure: six words held on in_valid behind a stalling COMPUTE
        burst[0] = 16'h0101; burst[1] = 16'h0202; burst[2] = 16'h0303;
        burst[3] = 16'h0404; burst[4] = 16'h0505; burst[5] = 16'h0606;
        applyStimulus(1'b1, 16'h6000, 1'b0, 1'b0, 8'h00);
        idx   = 0;
        guard = 0;
        while (idx < 6 && guard < 40) begin
            applyStimulus(1'b1, burst[idx], 1'b0, 1'b0, 8'h00);
            if (expReady) idx++;
            guard++;
        end
        checkOutput("burst_accepted", idx, 6);
        idleCycles(10);

        // Flush during WAITRD with two words queued, then a fresh push
        applyStimulus(1'b1, 16'h8000, 1'b0, 1'b0, 8'h11);
        applyStimulus(1'b1, 16'h0AAA, 1'b0, 1'b0, 8'h22);
        applyStimulus(1'b1, 16'h0BBB, 1'b0, 1'b0, 8'h33);
        applyStimulus(1'b1, 16'h0CCC, 1'b1, 1'b0, 8'h44);
        applyStimulus(1'b1, 16'h1357, 1'b0, 1'b0, 8'h55);
        idleCycles(4);

        // Reset in the middle of a COMPUTE stall with another COMPUTE queued
        applyStimulus(1'b1, 16'h6000, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 16'h6001, 1'b0, 1'b0, 8'h00);
        idleCycles(2);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 8'h00);
        idleCycles(10);

        // Random traffic with occasional flush and reset
        for (int n = 0; n < 3000; n++) begin
            op = 3'($urandom_range(7));
            rw = {op, 13'($urandom)};
            if ($urandom_range(15) == 0) rw = 16'h0000;
            applyStimulus(1'($urandom_range(99) < 60), rw,
                          1'($urandom_range(99) < 3),
                          1'($urandom_range(99) < 2),
                          8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
